// File: rtl/instr_queue_pkg.sv
// Shared types and default widths for the fetch -> decode instruction queue.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
// Contents: INSTR_WIDTH_DEF, PC_WIDTH_DEF, instr_entry_t {instr, pc} at default widths.
package instr_queue_pkg;

  localparam int INSTR_WIDTH_DEF = 32;
  localparam int PC_WIDTH_DEF    = 32;

  // Entry format exchanged by fetch and decode at the default widths.
  typedef struct packed {
    logic [INSTR_WIDTH_DEF-1:0] instr;
    logic [PC_WIDTH_DEF-1:0]    pc;
  } instr_entry_t;

endpackage

// File: rtl/instr_queue_ptr.sv
// Lap-bit ring pointer ($clog2(DEPTH)+1 bits) used for the queue head and tail.
// Latency: ptr updates on the rising edge after clear/incr.
// Backpressure: none; clear (and reset) takes priority over incr.
// Ports: clk, rst_n (sync, active-low), clear, incr -> ptr.
module instr_queue_ptr #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     incr,
  output logic [$clog2(DEPTH):0]   ptr
);

  // DEPTH is a power of two, so a plain binary increment wraps the index
  // from DEPTH-1 to 0 and carries into the lap bit on its own.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      ptr <= '0;
    end else if (incr) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/instr_queue.sv
// In-order instruction queue between fetch and decode with PC payload, count and flush.
// Latency: push-to-pop 1 cycle (0 cycles on an empty queue when INSTR_QUEUE_BYPASS_EN is defined).
// Backpressure: enq_ready drops when full, in flush or in reset; a full queue takes no push alongside a pop.
// Ports: clk, rst_n (sync, active-low), flush; enq_valid/enq_ready/enq_instr/enq_pc;
//        deq_valid/deq_ready/deq_instr/deq_pc (zero when not valid); count, is_empty, is_full.
// Optional macro: INSTR_QUEUE_BYPASS_EN enables the empty-queue combinational bypass.
module instr_queue
  import instr_queue_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
  parameter int PC_WIDTH    = PC_WIDTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [INSTR_WIDTH-1:0]   enq_instr,
  input  logic [PC_WIDTH-1:0]      enq_pc,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [INSTR_WIDTH-1:0]   deq_instr,
  output logic [PC_WIDTH-1:0]      deq_pc,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     is_empty,
  output logic                     is_full
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    logic [PC_WIDTH-1:0]    pc;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic            q_vld;
  logic            enq_fire;
  logic            push;
  logic            pop;
  entry_t          head_ent;
  entry_t          enq_ent;
  entry_t          out_ent;

  assign is_empty = (head == tail);
  // Same slot index but different lap: tail has gone exactly one lap ahead.
  assign is_full  = (head[IW-1:0] == tail[IW-1:0]) && (head[PW-1] != tail[PW-1]);
  assign count    = tail - head;

  assign enq_ready = !is_full && !flush && rst_n;
  assign q_vld     = !is_empty && !flush && rst_n;
  assign enq_fire  = enq_valid && enq_ready;

  assign head_ent  = mem[head[IW-1:0]];
  assign enq_ent   = '{instr: enq_instr, pc: enq_pc};

`ifdef INSTR_QUEUE_BYPASS_EN
  logic byp;

  // Empty queue: present the incoming entry directly at the head.
  assign byp       = is_empty && enq_valid && !flush && rst_n;
  assign deq_valid = q_vld || byp;
  assign out_ent   = byp ? enq_ent : head_ent;
  // A bypassed entry taken by decode is never written; one that is not
  // taken falls through to a normal enqueue. The head never advances on a
  // bypass because the stored queue is empty.
  assign push      = enq_fire && !(byp && deq_ready);
  assign pop       = deq_valid && deq_ready && !byp;
`else
  assign deq_valid = q_vld;
  assign out_ent   = head_ent;
  assign push      = enq_fire;
  assign pop       = deq_valid && deq_ready;
`endif

  assign deq_instr = deq_valid ? out_ent.instr : '0;
  assign deq_pc    = deq_valid ? out_ent.pc    : '0;

  instr_queue_ptr #(.DEPTH(DEPTH)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .incr  (pop),
    .ptr   (head)
  );

  instr_queue_ptr #(.DEPTH(DEPTH)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .incr  (push),
    .ptr   (tail)
  );

  // Storage is not reset; push is already gated off by reset and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[tail[IW-1:0]] <= enq_ent;
    end
  end

endmodule
